d8_loader: RTL and testbench



---
 rtl/d8_loader_pkg.sv | 25 ++
 rtl/d8_uart_rx.sv | 97 +++++++++
 rtl/d8_loader.sv | 138 +++++++++++++
 tb/tb_d8_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/d8_loader_pkg.sv
// Shared definitions for the d8 serial boot loader: defaults and state encodings.
package d8_loader_pkg;

    localparam int         DEF_CLK_PER_BIT = 868;        // 100 MHz / 115200 baud
    localparam int         DEF_TIMEOUT     = 1_000_000;  // idle cycles tolerated inside a frame
    localparam logic [7:0] DEF_SYNC        = 8'hA5;      // frame start byte

    // Frame-level loader states
    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE
    } ld_state_t;

    // UART receiver states
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/d8_uart_rx.sv
// 8N1 UART receiver: synchronizes rx, finds the start bit, samples mid-bit and
// reports either a good byte (stb) or a framing error (ferr), one cycle each.
module d8_uart_rx
    import d8_loader_pkg::*;
#(
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    output logic       stb,
    output logic [7:0] data,
    output logic       ferr
);

    localparam int CW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 2;

    rx_state_t       state, state_next;
    logic            sync1, sync2, prev;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shift;
    logic            half_tick, full_tick;

    assign half_tick = (cnt == CW'(CLK_PER_BIT / 2 - 1));
    assign full_tick = (cnt == CW'(CLK_PER_BIT - 1));

    // State register; reset discards any bit in progress
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) state <= RX_IDLE;
        else          state <= state_next;
    end

    // Next-state: a start bit that is high again at mid-bit is a glitch
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (prev && !sync2) state_next = RX_START;
            RX_START: if (half_tick) state_next = sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_tick && idx == 3'd7) state_next = RX_STOP;
            RX_STOP:  if (full_tick) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    // Synchronizer, bit timer, shift register and result strobes
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            stb   <= 1'b0;
            data  <= '0;
            ferr  <= 1'b0;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            prev  <= sync2;
            stb   <= 1'b0;
            ferr  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                end
                RX_START: cnt <= half_tick ? '0 : cnt + CW'(1);
                RX_DATA: begin
                    if (full_tick) begin
                        cnt   <= '0;
                        shift <= {sync2, shift[7:1]};
                        idx   <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (full_tick) begin
                        cnt <= '0;
                        if (sync2) begin
                            stb  <= 1'b1;
                            data <= shift;
                        end else begin
                            ferr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/d8_loader.sv
// Serial boot loader: parses SYNC/LEN/data/CSUM frames from the UART, writes
// the payload into memi and releases the d8 core reset on a good checksum.
module d8_loader
    import d8_loader_pkg::*;
#(
    parameter int         CLK_PER_BIT = DEF_CLK_PER_BIT,
    parameter int         TIMEOUT     = DEF_TIMEOUT,
    parameter logic [7:0] SYNC        = DEF_SYNC
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    output logic       mem_we,
    output logic [7:0] mem_adr,
    output logic [7:0] mem_dat,
    output logic       cpu_rst,
    output logic       load_ok,
    output logic       load_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;

    ld_state_t     state, state_next;
    logic          rx_stb, rx_ferr;
    logic [7:0]    rx_byte;
    logic [8:0]    len;      // 9 bits so LEN=0 can stand for 256
    logic [7:0]    csum;
    logic [TW-1:0] timer;
    logic          tmo, abort;

    d8_uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .rx      (rx),
        .stb     (rx_stb),
        .data    (rx_byte),
        .ferr    (rx_ferr)
    );

    assign tmo   = (timer == TW'(TIMEOUT - 1)) && !rx_stb;
    assign abort = rx_ferr || tmo;

    // State register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) state <= IDLE;
        else          state <= state_next;
    end

    // Frame sequencing; SYNC inside a frame is plain data, no resync
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (rx_stb && rx_byte == SYNC) state_next = LEN;
            LEN: begin
                if (abort)       state_next = IDLE;
                else if (rx_stb) state_next = DATA;
            end
            DATA: begin
                if (abort)                     state_next = IDLE;
                else if (rx_stb && len == 9'd1) state_next = CSUM;
            end
            CSUM: begin
                if (abort)       state_next = IDLE;
                else if (rx_stb) state_next = (rx_byte == csum) ? DONE : IDLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Inter-byte timeout counter, live only while a frame is open
    always_ff @(posedge sys_clk) begin
        if (!sys_rst || state == IDLE || state == DONE || rx_stb || abort)
            timer <= '0;
        else
            timer <= timer + TW'(1);
    end

    // Memory write port, checksum, length and status flags
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            mem_we   <= 1'b0;
            mem_adr  <= '0;
            mem_dat  <= '0;
            cpu_rst  <= 1'b1;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
            len      <= '0;
            csum     <= '0;
        end else begin
            mem_we <= 1'b0;
            // Address advances right after each write; 8-bit wrap only after a 256-byte frame
            if (mem_we) mem_adr <= mem_adr + 8'd1;
            case (state)
                IDLE: begin
                    if (rx_stb && rx_byte == SYNC) begin
                        cpu_rst  <= 1'b1;
                        load_ok  <= 1'b0;
                        load_err <= 1'b0;
                    end
                end
                LEN: begin
                    if (abort) begin
                        load_err <= 1'b1;
                        cpu_rst  <= 1'b1;
                    end else if (rx_stb) begin
                        len     <= {(rx_byte == 8'd0), rx_byte};
                        csum    <= '0;
                        mem_adr <= '0;
                    end
                end
                DATA: begin
                    if (abort) begin
                        load_err <= 1'b1;
                        cpu_rst  <= 1'b1;
                    end else if (rx_stb) begin
                        mem_dat <= rx_byte;
                        mem_we  <= 1'b1;
                        csum    <= csum + rx_byte;
                        len     <= len - 9'd1;
                    end
                end
                CSUM: begin
                    if (abort || (rx_stb && rx_byte != csum)) begin
                        load_err <= 1'b1;
                        cpu_rst  <= 1'b1;
                    end
                end
                DONE: begin
                    load_ok <= 1'b1;
                    cpu_rst <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_d8_loader.sv
// Directed bench for d8_loader with a write scoreboard fed from the stimulus.
module tb_d8_loader;

    localparam int BIT = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       rx;
    logic       mem_we;
    logic [7:0] mem_adr;
    logic [7:0] mem_dat;
    logic       cpu_rst;
    logic       load_ok;
    logic       load_err;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_we = 0;
    int         we_cnt = 0;
    int         n0;
    int         delta;
    logic [15:0] exp_q[$];
    logic [7:0]  payload[$];

    d8_loader #(.CLK_PER_BIT(BIT), .TIMEOUT(500), .SYNC(8'hA5)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .rx       (rx),
        .mem_we   (mem_we),
        .mem_adr  (mem_adr),
        .mem_dat  (mem_dat),
        .cpu_rst  (cpu_rst),
        .load_ok  (load_ok),
        .load_err (load_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Write monitor: every mem_we must match the next expected (adr, dat)
    always @(negedge sys_clk) begin
        logic [15:0] e;
        cyc++;
        if (mem_we === 1'b1) begin
            we_cnt++;
            last_we = cyc;
            checks++;
            assert (cpu_rst === 1'b1) else begin
                errors++;
                $error("FAIL we_while_running observed cpu_rst=%b expected 1", cpu_rst);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL unexpected_write observed adr=%0h dat=%0h expected none", mem_adr, mem_dat);
            end else begin
                e = exp_q.pop_front();
                assert ({mem_adr, mem_dat} === e) else begin
                    errors++;
                    $error("FAIL write observed adr=%0h dat=%0h expected adr=%0h dat=%0h",
                           mem_adr, mem_dat, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BIT);
        end
        rx = stop;
        tick(BIT);
        rx = 1'b1;
    endtask

    // Sends SYNC, LEN, payload, CSUM and queues the expected writes
    task automatic send_frame(input logic [7:0] cs);
        send_byte(8'hA5, 1'b1);
        send_byte((payload.size() == 256) ? 8'h00 : 8'(payload.size()), 1'b1);
        foreach (payload[i]) begin
            exp_q.push_back({8'(i), payload[i]});
            send_byte(payload[i], 1'b1);
        end
        send_byte(cs, 1'b1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_we"},   mem_we,   0);
        chk({tag, "_adr"},  mem_adr,  0);
        chk({tag, "_dat"},  mem_dat,  0);
        chk({tag, "_cpu"},  cpu_rst,  1);
        chk({tag, "_ok"},   load_ok,  0);
        chk({tag, "_err"},  load_err, 0);
    endtask

    initial begin
        rx = 1'b1;
        sys_rst = 1'b0;
        tick(4);
        chk_reset_values("rst");
        sys_rst = 1'b1;
        tick(4);

        // Good 3-byte frame
        payload = '{8'h11, 8'h22, 8'h33};
        n0 = we_cnt;
        send_frame(8'h66);
        tick(3);
        chk("a_ok", load_ok, 1);
        chk("a_cpu", cpu_rst, 0);
        chk("a_err", load_err, 0);
        chk("a_writes", we_cnt - n0, 3);
        chk("a_pending", exp_q.size(), 0);

        // Same frame, wrong checksum
        n0 = we_cnt;
        send_frame(8'h67);
        tick(3);
        chk("b_err", load_err, 1);
        chk("b_ok", load_ok, 0);
        chk("b_cpu", cpu_rst, 1);
        chk("b_writes", we_cnt - n0, 3);

        // 256-byte frame (LEN=0), address wraps back to 0
        payload.delete();
        for (int i = 0; i < 256; i++) payload.push_back(8'(i));
        n0 = we_cnt;
        send_frame(8'h80);
        tick(3);
        chk("c_ok", load_ok, 1);
        chk("c_err", load_err, 0);
        chk("c_cpu", cpu_rst, 0);
        chk("c_adr_wrap", mem_adr, 0);
        chk("c_writes", we_cnt - n0, 256);
        chk("c_pending", exp_q.size(), 0);

        // Framing error during DATA aborts the frame
        n0 = we_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        exp_q.push_back({8'h00, 8'h11});
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        tick(200);
        chk("d_err", load_err, 1);
        chk("d_ok", load_ok, 0);
        chk("d_cpu", cpu_rst, 1);
        chk("d_writes", we_cnt - n0, 1);

        // Next valid frame loads normally
        payload = '{8'h5A};
        send_frame(8'h5A);
        tick(3);
        chk("e_ok", load_ok, 1);
        chk("e_err", load_err, 0);
        chk("e_cpu", cpu_rst, 0);
        chk("e_pending", exp_q.size(), 0);

        // Timeout after A5 02 01
        n0 = we_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        exp_q.push_back({8'h00, 8'h01});
        send_byte(8'h01, 1'b1);
        for (int k = 0; k < 1000 && load_err !== 1'b1; k++) tick(1);
        delta = cyc - last_we;
        chk("f_err", load_err, 1);
        checks++;
        assert (delta >= 495 && delta <= 505) else begin
            errors++;
            $error("FAIL timeout_delay observed=%0d expected=500", delta);
        end
        chk("f_writes", we_cnt - n0, 1);
        chk("f_cpu", cpu_rst, 1);

        // Reset asserted in the middle of a byte
        rx = 1'b0;
        tick(24);
        sys_rst = 1'b0;
        tick(1);
        chk_reset_values("g");
        rx = 1'b1;
        tick(5);
        sys_rst = 1'b1;
        tick(5);
        payload = '{8'h77};
        send_frame(8'h77);
        tick(3);
        chk("h_ok", load_ok, 1);
        chk("h_cpu", cpu_rst, 0);
        chk("h_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
